// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill path.
// The line geometry here must agree with the parameters of icache_line_refill.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEAT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RETRY = 3'd4
  } refill_state_t;

  localparam int BEATS            = 4;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int LINE_BYTES       = 16;

endpackage

// File: rtl/refill_line_buffer.sv
// Assembles one cache line from sequential memory beats, lowest word first.
// done_o flags the cycle in which the final beat of the line is written.
module refill_line_buffer
  import icache_pkg::*;
#(
  parameter int BEAT_WIDTH = 32,
  parameter int NUM_BEATS  = BEATS
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic                            we_i,
  input  logic [BEAT_WIDTH-1:0]           wdata_i,
  output logic                            done_o,
  output logic [NUM_BEATS*BEAT_WIDTH-1:0] line_o
);

  localparam int CNT_W = $clog2(NUM_BEATS);

  logic [CNT_W-1:0] beat_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      beat_cnt_reg <= '0;
    end else if (we_i) begin
      beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
    end
  end

  assign done_o = we_i && (beat_cnt_reg == CNT_W'(NUM_BEATS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BEATS; gi++) begin : g_word
      localparam logic [CNT_W-1:0] WORD_IDX = CNT_W'(gi);
      logic [BEAT_WIDTH-1:0] word_reg;

      always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
          word_reg <= '0;
        end else if (we_i && (beat_cnt_reg == WORD_IDX)) begin
          word_reg <= wdata_i;
        end
      end

      assign line_o[gi*BEAT_WIDTH +: BEAT_WIDTH] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/icache_line_refill.sv
// Instruction-cache miss/refill controller: fetches the current line on a miss,
// or the next line for a straddling instruction, and stalls the core meanwhile.
module icache_line_refill
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  hit_i,
  input  logic                  split_flag_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
  output logic                  line_we_o,
  output logic [ADDR_WIDTH-1:0] line_addr_o,
  output logic [BLOCK_SIZE-1:0] line_data_o,
  output logic                  stall_o
);

  localparam int LINE_BEATS = BLOCK_SIZE / BEAT_WIDTH;

  refill_state_t         state_reg;
  logic [ADDR_WIDTH-1:0] target_reg;
  logic                  mem_req_reg;
  logic                  line_we_reg;

  logic [ADDR_WIDTH-1:0] pc_line;
  logic                  buf_clear;
  logic                  buf_we;
  logic                  buf_done;
  logic                  unused_pc_offset;

  assign pc_line          = {pc_i[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  assign unused_pc_offset = ^pc_i[LINE_OFFSET_BITS-1:0];

  // Beats are only accepted while collecting; stragglers after a reset are dropped.
  assign buf_clear = (state_reg == ST_REQ) && mem_ready_i;
  assign buf_we    = (state_reg == ST_BEAT) && mem_rvalid_i;

  refill_line_buffer #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .NUM_BEATS  (LINE_BEATS)
  ) u_line_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (buf_clear),
    .we_i    (buf_we),
    .wdata_i (mem_rdata_i),
    .done_o  (buf_done),
    .line_o  (line_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      target_reg  <= '0;
      mem_req_reg <= 1'b0;
      line_we_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // A current-line miss wins over the straddle request.
          if (fetch_req_i && !hit_i) begin
            target_reg  <= pc_line;
            mem_req_reg <= 1'b1;
            state_reg   <= ST_REQ;
          end else if (fetch_req_i && hit_i && split_flag_i) begin
            target_reg  <= pc_line + ADDR_WIDTH'(LINE_BYTES);
            mem_req_reg <= 1'b1;
            state_reg   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready_i) begin
            mem_req_reg <= 1'b0;
            state_reg   <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (buf_done) begin
            line_we_reg <= 1'b1;
            state_reg   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          line_we_reg <= 1'b0;
          state_reg   <= ST_RETRY;
        end
        ST_RETRY: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          mem_req_reg <= 1'b0;
          line_we_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_reg;
  assign mem_addr_o  = target_reg;
  assign line_we_o   = line_we_reg;
  assign line_addr_o = target_reg;

  // Combinational in IDLE so the core holds its PC in the cycle the miss appears.
  assign stall_o = (state_reg != ST_IDLE) || (fetch_req_i && (!hit_i || split_flag_i));

endmodule

// File: tb/tb_icache_line_refill.sv
// Directed bench for icache_line_refill with a scoreboard of expected requests and line writes.
module tb_icache_line_refill;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         fetch_req_i;
  logic [31:0]  pc_i;
  logic         hit_i;
  logic         split_flag_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ready_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic         line_we_o;
  logic [31:0]  line_addr_o;
  logic [127:0] line_data_o;
  logic         stall_o;

  int checks   = 0;
  int errors   = 0;
  int we_count = 0;

  wr_t         exp_q[$];
  logic [31:0] req_q[$];

  always #5 clk_i = ~clk_i;

  icache_line_refill dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fetch_req_i  (fetch_req_i),
    .pc_i         (pc_i),
    .hit_i        (hit_i),
    .split_flag_i (split_flag_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .line_we_o    (line_we_o),
    .line_addr_o  (line_addr_o),
    .line_data_o  (line_data_o),
    .stall_o      (stall_o)
  );

  always @(negedge clk_i) begin
    if (line_we_o === 1'b1) we_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One complete refill: miss seen in cycle 0, optional ready wait and beat gaps.
  task automatic refill(input logic [31:0] pc, input logic hit, input logic split,
                        input logic [31:0] exp_addr, input int ready_wait, input int gap,
                        input bit drop_fetch, input logic [31:0] seed);
    logic [31:0]  d [4];
    logic [127:0] line;
    wr_t          wr;
    int           we_before;
    for (int k = 0; k < 4; k++) d[k] = seed * (k + 1);
    line = {d[3], d[2], d[1], d[0]};
    exp_q.push_back('{addr: exp_addr, data: line});
    req_q.push_back(exp_addr);
    we_before = we_count;

    fetch_req_i  = 1'b1;
    pc_i         = pc;
    hit_i        = hit;
    split_flag_i = split;
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    #1;
    check("stall_cycle0", stall_o, 1);

    step();
    check("mem_req_on", mem_req_o, 1);
    check("mem_addr", mem_addr_o, req_q.pop_front());
    for (int w = 0; w < ready_wait; w++) begin
      step();
      check("mem_req_held", mem_req_o, 1);
      check("mem_addr_stable", mem_addr_o, exp_addr);
    end
    mem_ready_i  = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    step();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    check("mem_req_off", mem_req_o, 0);

    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rvalid_i = 1'b0;
        step();
        check("gap_no_we", line_we_o, 0);
        check("gap_stall", stall_o, 1);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = d[k];
      if (drop_fetch && k == 1) fetch_req_i = 1'b0;
      step();
      if (k < 3) check("beat_no_we", line_we_o, 0);
      check("beat_stall", stall_o, 1);
    end
    mem_rvalid_i = 1'b0;

    check("line_we", line_we_o, 1);
    check("sb_pending", exp_q.size() > 0, 1);
    wr = exp_q.pop_front();
    check("line_addr", line_addr_o, wr.addr);
    check("line_data", line_data_o, wr.data);
    $display("refill pc=%h line_addr=%h line_data=%h", pc, line_addr_o, line_data_o);

    step();
    check("retry_we_off", line_we_o, 0);
    check("retry_stall", stall_o, 1);
    hit_i        = 1'b1;
    split_flag_i = 1'b0;

    step();
    check("idle_stall_off", stall_o, 0);
    check("idle_no_req", mem_req_o, 0);
    check("single_we", we_count - we_before, 1);
  endtask

  initial begin
    rst_i        = 1'b1;
    fetch_req_i  = 1'b0;
    pc_i         = '0;
    hit_i        = 1'b0;
    split_flag_i = 1'b0;
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_line_we", line_we_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_line_addr", line_addr_o, 0);
    check("rst_line_data", line_data_o, 0);
    check("rst_stall", stall_o, 0);

    // Hit with no straddle: no refill, no stall.
    fetch_req_i = 1'b1; pc_i = 32'h0000_0100; hit_i = 1'b1; split_flag_i = 1'b0;
    #1;
    check("hit_no_stall", stall_o, 0);
    step();
    check("hit_no_req", mem_req_o, 0);
    $display("hit pc=%h stall=%b", pc_i, stall_o);

    refill(32'h0000_1008, 1'b0, 1'b0, 32'h0000_1000, 0, 0, 1'b0, 32'h1111_1111);
    refill(32'h0000_203E, 1'b1, 1'b1, 32'h0000_2040, 0, 0, 1'b0, 32'h0BAD_F00D);
    refill(32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0000, 0, 0, 1'b0, 32'h1357_9BDF);
    refill(32'h0000_5004, 1'b0, 1'b1, 32'h0000_5000, 0, 0, 1'b0, 32'h2468_ACE0);
    refill(32'h0000_6010, 1'b0, 1'b0, 32'h0000_6010, 3, 1, 1'b0, 32'hCAFE_0001);
    refill(32'h0000_7ABC, 1'b0, 1'b0, 32'h0000_7AB0, 0, 0, 1'b1, 32'h5A5A_0003);

    // Reset after the second beat: partial line discarded, no write.
    begin
      int we_before;
      we_before    = we_count;
      fetch_req_i  = 1'b1; pc_i = 32'h0000_3000; hit_i = 1'b0; split_flag_i = 1'b0;
      mem_ready_i  = 1'b1;
      step();
      check("rst_case_req", mem_req_o, 1);
      step();
      mem_ready_i  = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hA0A0_0000 + k;
        step();
      end
      rst_i        = 1'b1;
      fetch_req_i  = 1'b0;
      mem_rdata_i  = 32'hBBBB_0002;
      step();
      rst_i = 1'b0;
      check("midrst_mem_req", mem_req_o, 0);
      check("midrst_line_we", line_we_o, 0);
      check("midrst_stall", stall_o, 0);
      check("midrst_line_data", line_data_o, 0);
      for (int k = 0; k < 3; k++) begin
        mem_rdata_i = 32'hCCCC_0000 + k;
        step();
        check("postrst_no_we", line_we_o, 0);
        check("postrst_no_req", mem_req_o, 0);
        check("postrst_stall", stall_o, 0);
      end
      mem_rvalid_i = 1'b0;
      check("postrst_line_data", line_data_o, 0);
      check("midrst_no_write", we_count - we_before, 0);
      $display("reset mid-refill pc=%h writes=%0d", pc_i, we_count - we_before);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
